tick_period_meter: RTL

Measures the interval, in `clk` cycles, between successive single-cycle `tick` strobes and hands each measurement out over a valid/ready port. It is the receive-side counterpart of the down-counting divider: it consumes the terminal-count pulse train that the divider produces and recovers the period. For a divider reload value N, the reported period is N+1. It sits in the lab's timing/display path, which uses it for self-checking the dividers and for measuring external strobe rates.

---
 rtl/meter_pkg.sv | 21 ++
 rtl/sat_up_counter.sv | 38 +++
 rtl/tick_period_meter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/meter_pkg.sv
// Shared types and constants for the tick period meter.
package meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        SAT   = 2'd2
    } meter_state_t;

    localparam int unsigned BIT_SIZE_DEFAULT = 28;

    // All-ones value of a w-bit field, returned right-aligned in 64 bits.
    function automatic logic [63:0] all_ones(input int unsigned w);
        if (w >= 64) begin
            return {64{1'b1}};
        end else begin
            return (64'd1 << w) - 64'd1;
        end
    endfunction

endpackage

// File: rtl/sat_up_counter.sv
// Up-counter with synchronous clear, load-of-one and saturation at all-ones.
module sat_up_counter
    import meter_pkg::*;
#(
    parameter int unsigned W = BIT_SIZE_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_load1,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt,
    output logic         o_at_max
);

    localparam logic [W-1:0] CNT_MAX = W'(all_ones(W));

    logic [W-1:0] r_cnt;

    // Clear has priority over load, load over increment; increment stops at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_load1) begin
            r_cnt <= W'(1);
        end else if (i_inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt    = r_cnt;
    assign o_at_max = (r_cnt == CNT_MAX);

endmodule

// File: rtl/tick_period_meter.sv
// Measures clk cycles between successive tick strobes; results leave on a valid/ready port.
module tick_period_meter
    import meter_pkg::*;
#(
    parameter int unsigned BIT_SIZE = BIT_SIZE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                tick,
    output logic [BIT_SIZE-1:0] period,
    output logic                ovf,
    output logic                valid,
    input  logic                ready,
    output logic                drop
);

    meter_state_t        r_state;
    meter_state_t        w_state_nxt;
    logic [BIT_SIZE-1:0] w_cnt;
    logic                w_at_max;
    logic                w_clear;
    logic                w_load1;
    logic                w_inc;
    logic                w_cap;
    logic                w_cap_ovf;
    logic                w_xfer;

    sat_up_counter #(
        .W (BIT_SIZE)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_load1  (w_load1),
        .i_inc    (w_inc),
        .o_cnt    (w_cnt),
        .o_at_max (w_at_max)
    );

    // Next-state and counter control; a tick while the count sits at all-ones in COUNT is an exact fit.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_load1     = 1'b0;
        w_inc       = 1'b0;
        w_cap       = 1'b0;
        w_cap_ovf   = 1'b0;
        if (!ena) begin
            w_state_nxt = IDLE;
            w_clear     = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (tick) begin
                        w_load1     = 1'b1;
                        w_state_nxt = COUNT;
                    end else begin
                        w_clear     = 1'b1;
                    end
                end
                COUNT: begin
                    if (tick) begin
                        w_cap   = 1'b1;
                        w_load1 = 1'b1;
                    end else if (w_at_max) begin
                        w_state_nxt = SAT;
                    end else begin
                        w_inc = 1'b1;
                    end
                end
                SAT: begin
                    if (tick) begin
                        w_cap       = 1'b1;
                        w_cap_ovf   = 1'b1;
                        w_load1     = 1'b1;
                        w_state_nxt = COUNT;
                    end else begin
                        w_state_nxt = SAT;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_clear     = 1'b1;
                end
            endcase
        end
    end

    assign w_xfer = valid && ready;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Result register: a capture is dropped only when the held result cannot leave this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period <= '0;
            ovf    <= 1'b0;
            valid  <= 1'b0;
            drop   <= 1'b0;
        end else begin
            drop <= w_cap && valid && !ready;
            if (w_cap && (!valid || ready)) begin
                period <= w_cnt;
                ovf    <= w_cap_ovf;
                valid  <= 1'b1;
            end else if (w_xfer) begin
                valid  <= 1'b0;
            end else begin
                valid  <= valid;
            end
        end
    end

endmodule
